mips_dmem_ctrl: RTL
===================

# mips_dmem_ctrl

Parametrised data-memory subsystem for the next-generation MIPS top. It replaces the bare data memory with a request/response controller that adds:
- configurable wait states;
- byte/half/word accesses with little-endian byte lanes and sign/zero extension;
- alignment and range checking.

It sits between `mips_core`'s load/store path and on-chip data RAM. The core stalls while `req_ready` or `rsp_valid` is pending.

## Interface
- `ADDR_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, word width; fixed at 32 (4 byte lanes); elaboration error otherwise
- `DEPTH`, 1024, RAM depth in words; power of two
- `WAIT_CYCLES`, 1, extra access latency, 0..7
---
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  access request
- `req_ready`  out  1  controller can accept a request this cycle
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  `mem_size_e`: byte/half/word; 2'b11 illegal
- `req_signed`  in  1  sign-extend loads (lb/lh); ignored for word and store
- `req_addr`  in  ADDR_WIDTH  byte address
- `req_wdata`  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0])
- `rsp_valid`  out  1  one-cycle completion pulse, for loads and stores
- `rsp_rdata`  out  DATA_WIDTH  extended load data; 0 for stores and errors
- `addr_exc`  out  1  qualifies `rsp_valid`: misaligned, illegal size, or out-of-range access

## Operation
- FSM states: IDLE, WAIT, RESP.
- `req_ready` = (state == IDLE) || (state == RESP).
- Accept when `req_valid && req_ready`. Latch `we`, `size`, `signed`, `addr`, `wdata`. Load wait counter with `WAIT_CYCLES`.
- Transitions out of IDLE/RESP on accept:
  - To WAIT if `WAIT_CYCLES` > 0.
  - Else directly to RESP.
  - RESP with no accept goes to IDLE.
- WAIT: counter decrements each cycle. At 1, go to RESP on the next edge.
- Commit edge (the edge entering RESP):
  - Stores write the enabled byte lanes.
  - Loads capture the RAM word, lane-selected and extended.
- Error check, evaluated at accept:
  - half with addr[0]=1;
  - word with addr[1:0]≠0;
  - `req_size`=2'b11;
  - `addr[ADDR_WIDTH-1:2]` ≥ DEPTH.
  - On error: no RAM access, no write. Same latency; RESP asserts `addr_exc`=1 with `rsp_rdata`=0.
- Lanes, little-endian:
  - byte: lane addr[1:0];
  - half: lanes {addr[1],0} and {addr[1],1};
  - word: all four.
- Load extension:
  - byte: lane byte to 32 bits;
  - half: lane half to 32 bits;
  - sign bit replicated if `req_signed`, else zero-filled.
- Requests while busy: `req_ready`=0. The requester holds `req_valid` and payload stable until accepted.
- Accept during RESP is allowed and is a simultaneous event. A load accepted in the RESP cycle of a store to the same word sees the new data, because the store committed on the edge entering RESP.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `addr_exc`=0, counter 0.
- RAM contents are not reset.
- Latency: `rsp_valid` is asserted exactly `WAIT_CYCLES`+1 cycles after the accept edge.
- Throughput: one access per `WAIT_CYCLES`+1 cycles when back-to-back.
- `rsp_valid`, `rsp_rdata` and `addr_exc` are registered and held for exactly one cycle.
- Reset mid-operation: an in-flight access is aborted. A store not yet committed does not write; no `rsp_valid` is produced.

## Structure
- `mips_pkg` additions:
  - `typedef enum logic [1:0] {MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10} mem_size_e;`
  - `dmem_state_e` (IDLE, WAIT, RESP);
  - `localparam MAX_WAIT_CYCLES = 7`.
- Sub-module `mips_dmem_ram`:
  - single-port, synchronous-write, byte-enable RAM;
  - ports `clk`, `we`, `be[3:0]`, `waddr`, `wdata`, `rdata`;
  - combinational read, captured by the controller at commit.
- The controller owns the FSM, counter, error check, lane steering and extension.

## Test plan
- `WAIT_CYCLES`=0: sw 0xDEADBEEF @0x10, then lw @0x10. Required: `rsp_rdata`=0xDEADBEEF; each `rsp_valid` 1 cycle after its accept, back-to-back with `req_ready` held 1.
- `WAIT_CYCLES`=3, data 0x80FF7F01 stored @0x20:
  - lb @0x23 → 0xFFFFFF80;
  - lbu @0x23 → 0x00000080;
  - lh @0x20 → 0x00007F01;
  - lhu @0x22 → 0x000080FF;
  - each response 4 cycles after accept.
- Partial stores: sw 0 @0x30, sb 0xAB @0x31, sh 0x1234 @0x32, lw @0x30. Required: 0x1234AB00.
- Errors, each with `rsp_valid`=1, `addr_exc`=1, `rsp_rdata`=0 and RAM unchanged:
  - lw @0x02;
  - sh @0x05;
  - size 2'b11;
  - word address DEPTH.
- Store accepted in RESP of a prior load, then lw of the same word. Required: the new value is returned.
- Reset mid-op: `WAIT_CYCLES`=5, sw 0x55 @0x40, `rst` pulsed at wait cycle 2. Required: no `rsp_valid`; outputs at reset values; later lw @0x40 returns the pre-store value.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS types: data-memory access sizes, controller states and the
// byte-lane helper functions used by the data-memory controller.
package mips_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_e;

    localparam int unsigned MAX_WAIT_CYCLES = 7;

    // Size/offset combinations that cannot be served (range is checked separately).
    function automatic logic size_align_error(input logic [1:0] size, input logic [1:0] off);
        logic err;
        case (size)
            MEM_BYTE: err = 1'b0;
            MEM_HALF: err = off[0];
            MEM_WORD: err = (off != 2'b00);
            default:  err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            MEM_BYTE: be = 4'b0001 << off;
            MEM_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            MEM_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data so every candidate lane carries it.
    function automatic logic [31:0] store_align(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            MEM_BYTE: d = {4{wdata[7:0]}};
            MEM_HALF: d = {2{wdata[15:0]}};
            MEM_WORD: d = wdata;
            default:  d = 32'h0000_0000;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            MEM_BYTE: r = {{24{sgn & b[7]}}, b};
            MEM_HALF: r = {{16{sgn & h[15]}}, h};
            MEM_WORD: r = word;
            default:  r = 32'h0000_0000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mips_dmem_ram.sv
// Single-port data RAM: synchronous byte-enabled write, combinational read
// of the same word address.
module mips_dmem_ram #(
    parameter int DEPTH     = 1024,
    parameter int ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [3:0]           be,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem_r [DEPTH];

    // Byte-lane write on the commit edge
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[waddr];

endmodule

// File: rtl/mips_dmem_ctrl.sv
// Data-memory request/response controller: wait states, byte/half/word
// lane steering with load extension, and alignment/range checking.
module mips_dmem_ctrl
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  addr_exc
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("mips_dmem_ctrl: DATA_WIDTH must be 32");
    end
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("mips_dmem_ctrl: DEPTH must be a power of two >= 2");
    end
    if ((WAIT_CYCLES < 0) || (WAIT_CYCLES > MAX_WAIT_CYCLES)) begin : g_bad_wait
        $error("mips_dmem_ctrl: WAIT_CYCLES out of range");
    end
    if (ADDR_WIDTH < AW + 2) begin : g_bad_addr
        $error("mips_dmem_ctrl: ADDR_WIDTH too small for DEPTH");
    end

    dmem_state_e       state_r, state_n_s;
    logic [2:0]        cnt_r;
    logic              we_r, sgn_r, err_r;
    logic [1:0]        size_r;
    logic [AW+1:0]     addr_r;
    logic [31:0]       wdata_r;
    logic              rsp_valid_r, addr_exc_r;
    logic [31:0]       rsp_rdata_r;

    logic              ready_s, accept_s, commit_s, bypass_s, err_s;
    logic              acc_we_s, acc_sgn_s, acc_err_s;
    logic [1:0]        acc_size_s;
    logic [AW+1:0]     acc_addr_s;
    logic [31:0]       acc_wdata_s;
    logic              ram_we_s;
    logic [3:0]        ram_be_s;
    logic [AW-1:0]     ram_addr_s;
    logic [31:0]       ram_wdata_s, ram_rdata_s, load_data_s;

    assign err_s = size_align_error(req_size, req_addr[1:0])
                || ((req_addr >> (AW + 2)) != {ADDR_WIDTH{1'b0}});

    // Acceptance and next-state; commit marks the edge that enters RESP
    always_comb begin
        ready_s   = (state_r == IDLE) || (state_r == RESP);
        accept_s  = req_valid && ready_s;
        state_n_s = state_r;
        commit_s  = 1'b0;
        case (state_r)
            IDLE, RESP: begin
                if (accept_s) begin
                    if (WAIT_CYCLES > 0) begin
                        state_n_s = WAIT;
                    end else begin
                        state_n_s = RESP;
                        commit_s  = 1'b1;
                    end
                end else begin
                    state_n_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r <= 3'd1) begin
                    state_n_s = RESP;
                    commit_s  = 1'b1;
                end else begin
                    state_n_s = WAIT;
                end
            end
            default: begin
                state_n_s = IDLE;
            end
        endcase
        bypass_s = accept_s && commit_s;
    end

    // Commit-path steering; with zero wait states the live request commits directly
    always_comb begin
        if (bypass_s) begin
            acc_we_s    = req_we;
            acc_sgn_s   = req_signed;
            acc_err_s   = err_s;
            acc_size_s  = req_size;
            acc_addr_s  = req_addr[AW+1:0];
            acc_wdata_s = req_wdata;
        end else begin
            acc_we_s    = we_r;
            acc_sgn_s   = sgn_r;
            acc_err_s   = err_r;
            acc_size_s  = size_r;
            acc_addr_s  = addr_r;
            acc_wdata_s = wdata_r;
        end
        ram_we_s    = commit_s && acc_we_s && !acc_err_s;
        ram_be_s    = lane_enable(acc_size_s, acc_addr_s[1:0]);
        ram_wdata_s = store_align(acc_size_s, acc_wdata_s);
        ram_addr_s  = acc_addr_s[AW+1:2];
        if (acc_we_s || acc_err_s) begin
            load_data_s = 32'h0000_0000;
        end else begin
            load_data_s = load_extend(ram_rdata_s, acc_size_s, acc_addr_s[1:0], acc_sgn_s);
        end
    end

    mips_dmem_ram #(
        .DEPTH     (DEPTH),
        .ADDR_BITS (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we_s),
        .be    (ram_be_s),
        .waddr (ram_addr_s),
        .wdata (ram_wdata_s),
        .rdata (ram_rdata_s)
    );

    // FSM state, request latch and wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 3'd0;
            we_r    <= 1'b0;
            sgn_r   <= 1'b0;
            err_r   <= 1'b0;
            size_r  <= 2'b00;
            addr_r  <= {(AW+2){1'b0}};
            wdata_r <= 32'h0000_0000;
        end else begin
            state_r <= state_n_s;
            if (accept_s) begin
                cnt_r   <= WAIT_INIT;
                we_r    <= req_we;
                sgn_r   <= req_signed;
                err_r   <= err_s;
                size_r  <= req_size;
                addr_r  <= req_addr[AW+1:0];
                wdata_r <= req_wdata;
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r - 3'd1;
            end
        end
    end

    // One-cycle registered response on the commit edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            addr_exc_r  <= 1'b0;
        end else if (commit_s) begin
            rsp_valid_r <= 1'b1;
            rsp_rdata_r <= load_data_s;
            addr_exc_r  <= acc_err_s;
        end else begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            addr_exc_r  <= 1'b0;
        end
    end

    assign req_ready = ready_s;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign addr_exc  = addr_exc_r;

endmodule
